// File: rtl/bubble_sorter_pkg.sv
// Shared types and constants for the bubble sorter slice.
// Sample width and FSM state encodings live here so every file agrees on them.
package bubble_sorter_pkg;

  localparam int DATA_W = 3;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    SORT  = 2'b01,
    DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/bubble_sorter_comparator.sv
// Unsigned magnitude comparator on two DATA_W-bit samples.
// Exactly one of gt, lt, eq is high for any input pair.
module simple_comparator
  import bubble_sorter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic              lt,
  output logic              eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/bubble_sorter.sv
// Batch sorter: loads DEPTH samples, bubble-sorts them in place with one
// compare-and-swap per cycle, then streams them out in ascending order.
module bubble_sorter
  import bubble_sorter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
  logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
  logic [IDX_W-1:0] i_reg, i_next;
  logic [IDX_W-1:0] limit_reg, limit_next;
  logic             swapped_reg, swapped_next;

  logic [IDX_W-1:0]  j_idx;
  logic [DATA_W-1:0] a_val, b_val;
  logic              gt;
  logic              wr_en, swap_en, swapped_now;

  assign j_idx = i_reg + ONE;
  assign a_val = mem[i_reg];
  assign b_val = mem[j_idx];

  simple_comparator u_cmp (
    .a  (a_val),
    .b  (b_val),
    .gt (gt),
    .lt (),
    .eq ()
  );

  // A pass continues if any swap happened so far, including this cycle's.
  assign swapped_now = swapped_reg | gt;

  always_comb begin
    state_next   = state_reg;
    wr_idx_next  = wr_idx_reg;
    rd_idx_next  = rd_idx_reg;
    i_next       = i_reg;
    limit_next   = limit_reg;
    swapped_next = swapped_reg;
    wr_en        = 1'b0;
    swap_en      = 1'b0;
    case (state_reg)
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_idx_reg == LAST_IDX) begin
            wr_idx_next  = '0;
            i_next       = '0;
            limit_next   = LAST_IDX;
            swapped_next = 1'b0;
            state_next   = SORT;
          end else begin
            wr_idx_next = wr_idx_reg + ONE;
          end
        end
      end
      SORT: begin
        swap_en = gt;
        if (i_reg < (limit_reg - ONE)) begin
          i_next       = i_reg + ONE;
          swapped_next = swapped_now;
        end else if (swapped_now && (limit_reg > ONE)) begin
          limit_next   = limit_reg - ONE;
          i_next       = '0;
          swapped_next = 1'b0;
        end else begin
          rd_idx_next = '0;
          state_next  = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_idx_reg == LAST_IDX) begin
            rd_idx_next = '0;
            state_next  = LOAD;
          end else begin
            rd_idx_next = rd_idx_reg + ONE;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= LOAD;
      wr_idx_reg  <= '0;
      rd_idx_reg  <= '0;
      i_reg       <= '0;
      limit_reg   <= '0;
      swapped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wr_idx_reg  <= wr_idx_next;
      rd_idx_reg  <= rd_idx_next;
      i_reg       <= i_next;
      limit_reg   <= limit_next;
      swapped_reg <= swapped_next;
    end
  end

  // Sample storage carries no reset; loads and swaps never overlap.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx_reg] <= in_data;
    end else if (swap_en) begin
      mem[i_reg] <= b_val;
      mem[j_idx] <= a_val;
    end
  end

  assign in_ready  = (state_reg == LOAD);
  assign busy      = (state_reg == SORT);
  assign out_valid = (state_reg == DRAIN);
  assign out_data  = (state_reg == DRAIN) ? mem[rd_idx_reg] : '0;

endmodule

// File: tb/tb_bubble_sorter.sv
// Directed bench for bubble_sorter (DEPTH=8): loads batches, measures sort
// time, and checks the drained order, backpressure and mid-sort reset.
module tb_bubble_sorter;

  typedef logic [2:0] vec_t [8];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = 3'd0;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;

  int total = 0;
  int bad = 0;

  bubble_sorter #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Feeds one batch; optionally leaves in_valid high with data 7 afterwards.
  task automatic load_batch(input vec_t v, input bit hold7, output int accepts);
    int guard;
    accepts = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = v[k];
      guard = 0;
      while (!in_ready && guard < 50) begin
        step();
        guard++;
      end
      if (in_ready) accepts++;
      $display("load[%0d] data=%0d in_ready=%0b", k, v[k], in_ready);
      step();
    end
    in_valid = hold7;
    in_data  = hold7 ? 3'd7 : 3'd0;
  endtask

  // Counts SORT cycles until out_valid; flags in_ready seen high meanwhile.
  task automatic sort_wait(output int busy_cycles, output bit timed_out,
                           output int ready_seen);
    int guard;
    busy_cycles = 0;
    ready_seen  = 0;
    guard = 0;
    while (!out_valid && guard < 200) begin
      if (busy) busy_cycles++;
      if (in_ready) ready_seen++;
      step();
      guard++;
    end
    timed_out = !out_valid;
  endtask

  // Drains a batch with out_ready held high; counts idle cycles in between.
  task automatic drain_all(output vec_t got, output int gaps);
    int n;
    int guard;
    n = 0;
    gaps = 0;
    guard = 0;
    out_ready = 1'b1;
    while (n < 8 && guard < 100) begin
      if (out_valid) begin
        got[n] = out_data;
        $display("drain[%0d] data=%0d", n, out_data);
        n++;
      end else begin
        gaps++;
      end
      step();
      guard++;
    end
    for (int k = n; k < 8; k++) got[k] = 3'bxxx;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    total++; if (out_data !== 3'd0) begin bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
  endtask

  task automatic test_unsorted;
    vec_t v = '{3'd5, 3'd3, 3'd7, 3'd0, 3'd6, 3'd1, 3'd4, 3'd2};
    vec_t exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    vec_t got;
    int acc, bc, rs, gaps;
    bit to;
    out_ready = 1'b1;
    load_batch(v, 1'b0, acc);
    total++; if (acc != 8) begin bad++; $display("FAIL unsorted_accepts: got %0d expected 8", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL unsorted_ready_after_load: got %0b expected 0", in_ready); end
    sort_wait(bc, to, rs);
    total++; if (to) begin bad++; $display("FAIL unsorted_timeout: got timeout expected out_valid"); end
    drain_all(got, gaps);
    total++; if (gaps != 0) begin bad++; $display("FAIL unsorted_valid_gaps: got %0d expected 0", gaps); end
    for (int k = 0; k < 8; k++) begin
      total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL unsorted_out[%0d]: got %0d expected %0d", k, got[k], exp[k]); end
    end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL unsorted_back_to_load: got valid=%0b ready=%0b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_sorted;
    vec_t v = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    vec_t got;
    int acc, bc, rs, gaps;
    bit to;
    load_batch(v, 1'b0, acc);
    sort_wait(bc, to, rs);
    total++; if (bc != 7) begin bad++; $display("FAIL sorted_busy_cycles: got %0d expected 7", bc); end
    total++; if (to || busy !== 1'b0) begin bad++; $display("FAIL sorted_valid_after_busy: got busy=%0b timeout=%0b expected 0/0", busy, to); end
    drain_all(got, gaps);
    for (int k = 0; k < 8; k++) begin
      total++; if (got[k] !== v[k]) begin bad++; $display("FAIL sorted_out[%0d]: got %0d expected %0d", k, got[k], v[k]); end
    end
  endtask

  task automatic test_reversed;
    vec_t v = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    vec_t exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    vec_t got;
    int acc, bc, rs, gaps;
    bit to;
    load_batch(v, 1'b0, acc);
    sort_wait(bc, to, rs);
    total++; if (bc != 28) begin bad++; $display("FAIL reversed_busy_cycles: got %0d expected 28", bc); end
    drain_all(got, gaps);
    for (int k = 0; k < 8; k++) begin
      total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL reversed_out[%0d]: got %0d expected %0d", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_duplicates;
    vec_t v = '{3'd3, 3'd3, 3'd1, 3'd3, 3'd1, 3'd7, 3'd7, 3'd0};
    vec_t exp = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd7, 3'd7};
    vec_t got;
    int acc, bc, rs, gaps;
    bit to;
    load_batch(v, 1'b0, acc);
    sort_wait(bc, to, rs);
    total++; if (bc > 28 || bc < 7) begin bad++; $display("FAIL dup_busy_cycles: got %0d expected 7..28", bc); end
    drain_all(got, gaps);
    for (int k = 0; k < 8; k++) begin
      total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL dup_out[%0d]: got %0d expected %0d", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_backpressure;
    vec_t v = '{3'd5, 3'd3, 3'd7, 3'd0, 3'd6, 3'd1, 3'd4, 3'd2};
    vec_t exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    vec_t got;
    int acc, bc, rs, n, cyc, drain_ready;
    bit to, stalled;
    logic [2:0] held;
    out_ready = 1'b0;
    load_batch(v, 1'b1, acc);
    sort_wait(bc, to, rs);
    total++; if (rs != 0) begin bad++; $display("FAIL bp_ready_in_sort: got %0d cycles expected 0", rs); end
    n = 0;
    cyc = 0;
    drain_ready = 0;
    stalled = 1'b0;
    held = 3'd0;
    while (n < 8 && cyc < 100) begin
      out_ready = (cyc % 2 == 0);
      if (in_ready) drain_ready++;
      if (stalled) begin
        total++; if (out_data !== held) begin bad++; $display("FAIL bp_hold: got %0d expected %0d", out_data, held); end
      end
      if (out_valid && out_ready) begin
        got[n] = out_data;
        $display("bp_drain[%0d] data=%0d", n, out_data);
        n++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = 3'd0;
    out_ready = 1'b1;
    total++; if (drain_ready != 0) begin bad++; $display("FAIL bp_ready_in_drain: got %0d cycles expected 0", drain_ready); end
    total++; if (n != 8) begin bad++; $display("FAIL bp_count: got %0d expected 8", n); end
    for (int k = 0; k < n; k++) begin
      total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL bp_out[%0d]: got %0d expected %0d", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_reset_mid_sort;
    vec_t v = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    vec_t v2 = '{3'd2, 3'd2, 3'd0, 3'd1, 3'd7, 3'd5, 3'd4, 3'd6};
    vec_t exp = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    vec_t got;
    int acc, bc, rs, gaps;
    bit to;
    load_batch(v, 1'b0, acc);
    for (int k = 0; k < 9; k++) step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before_rst: got %0b expected 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %0b expected 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %0b expected 0", out_valid); end
    total++; if (out_data !== 3'd0) begin bad++; $display("FAIL mid_rst_out_data: got %0d expected 0", out_data); end
    load_batch(v2, 1'b0, acc);
    sort_wait(bc, to, rs);
    drain_all(got, gaps);
    for (int k = 0; k < 8; k++) begin
      total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL mid_out[%0d]: got %0d expected %0d", k, got[k], exp[k]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_unsorted();
    test_sorted();
    test_reversed();
    test_duplicates();
    test_backpressure();
    test_reset_mid_sort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
